// File: rtl/ffsr_spike_encoder_if.sv
// Target handshake bundle for the FFSR spike encoder: the producer drives target/valid,
// and the encoder answers with ready.
interface ffsr_spike_encoder_if #(
  parameter int W = 3
);
  logic [W-1:0] target;
  logic         target_valid;
  logic         target_ready;

  modport master (output target, output target_valid, input target_ready);
  modport slave  (input target, input target_valid, output target_ready);
endinterface

// File: rtl/ffsr_spike_encoder.sv
// FFSR spike encoder: turns a requested count into active-low inc/dec spikes for the downstream counter.
// Optional FFSR_SPIKE_ENC_RETARGET_EN lets a new target be accepted during the inter-spike gap.
module ffsr_spike_encoder #(
  parameter int W   = 3,
  parameter int GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ffsr_spike_encoder_if.slave  tgt_if,
  output logic                 inc,
  output logic                 dec,
  output logic [W-1:0]         level,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP);

  state_t       state, state_d;
  logic [W-1:0] tgt_q, tgt_d, tgt_eff, level_d;
  logic         dir_q, dir_d;
  logic [3:0]   gap_q, gap_d;
  logic         accept, inc_d, dec_d, done_d;

  function automatic logic [W-1:0] step_sat(input logic [W-1:0] v, input logic up);
    if (up) return (v == {W{1'b1}}) ? v : v + W'(1);
    else    return (v == '0) ? v : v - W'(1);
  endfunction

`ifdef FFSR_SPIKE_ENC_RETARGET_EN
  assign tgt_if.target_ready = (state == IDLE) || (state == HIGH);
`else
  assign tgt_if.target_ready = (state == IDLE);
`endif

  assign accept  = tgt_if.target_valid & tgt_if.target_ready;
  // A target accepted on this edge must steer the decision made on the same edge.
  assign tgt_eff = accept ? tgt_if.target : tgt_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && (tgt_if.target != level)) state_d = LOW;
      LOW:     state_d = HIGH;
      HIGH:    if (gap_q == 4'd1) state_d = (tgt_eff != level) ? LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d   = tgt_eff;
    dir_d   = dir_q;
    gap_d   = gap_q;
    level_d = level;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        dir_d  = (tgt_eff > level);
        done_d = accept && (tgt_if.target == level);
      end
      LOW: begin
        level_d = step_sat(level, dir_q);
        gap_d   = GAP_LD;
      end
      HIGH: begin
        dir_d = (tgt_eff > level);
        if (gap_q == 4'd1) done_d = (tgt_eff == level);
        else               gap_d  = gap_q - 4'd1;
      end
      default: ;
    endcase
    // Lines are registered from the next state so each spike is a clean flop output.
    inc_d = !((state_d == LOW) && dir_d);
    dec_d = !((state_d == LOW) && !dir_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc   <= 1'b1;
      dec   <= 1'b1;
      done  <= 1'b0;
      level <= '0;
      tgt_q <= '0;
      dir_q <= 1'b0;
      gap_q <= GAP_LD;
    end else begin
      inc   <= inc_d;
      dec   <= dec_d;
      done  <= done_d;
      level <= level_d;
      tgt_q <= tgt_d;
      dir_q <= dir_d;
      gap_q <= gap_d;
    end
  end

endmodule
